// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: shadows load data, rotates one digit per SCAN_DIV cycles.
// Outputs are registered; load-to-display latency is 2 cycles; no handshake, load is a strobe.
module seg_scan_driver #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     en,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blink,
   input  logic                  lz_blank,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp_n
);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = $clog2(BLINK_DIV);

   logic [SW-1:0]          scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
   logic                   phase_q, phase_d;
   logic [4*DIGITS-1:0]    data_q;
   logic [DIGITS-1:0]      en_q, dp_q, blink_q;
   logic [DIGITS-1:0]      an_d;
   logic [6:0]             seg_d;
   logic                   dp_n_d;

   logic                   scan_wrap, blink_wrap;
   logic [DIGITS-1:0]      lz_mask;
   logic                   zero_run;
   logic [3:0]             nib;
   logic                   show, dot;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_to_seg = 7'h40;
         4'h1: hex_to_seg = 7'h79;
         4'h2: hex_to_seg = 7'h24;
         4'h3: hex_to_seg = 7'h30;
         4'h4: hex_to_seg = 7'h19;
         4'h5: hex_to_seg = 7'h12;
         4'h6: hex_to_seg = 7'h02;
         4'h7: hex_to_seg = 7'h78;
         4'h8: hex_to_seg = 7'h00;
         4'h9: hex_to_seg = 7'h10;
         4'hA: hex_to_seg = 7'h08;
         4'hB: hex_to_seg = 7'h03;
         4'hC: hex_to_seg = 7'h46;
         4'hD: hex_to_seg = 7'h21;
         4'hE: hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   always_comb begin
      scan_wrap   = (scan_cnt_q == SW'(SCAN_DIV - 1));
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      idx_d       = idx_q;
      if (scan_wrap) begin
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      phase_d     = phase_q ^ blink_wrap;
   end

   // lz_mask[i]: digit i and everything above it are zero with no dot; digit 0 always shows
   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run & (data_q[4*i +: 4] == 4'h0) & ~dp_q[i];
         lz_mask[i] = zero_run;
      end
      lz_mask[0] = 1'b0;
   end

   always_comb begin
      nib  = 4'h0;
      show = 1'b0;
      dot  = 1'b0;
      an_d = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib  = data_q[4*i +: 4];
            dot  = dp_q[i];
            show = en_q[i] & ~(blink_q[i] & phase_q) & ~(lz_blank & lz_mask[i]);
            an_d[i] = ~show;
         end
      end
      seg_d  = show ? hex_to_seg(nib) : 7'h7F;
      dp_n_d = ~(show & dot);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         data_q      <= '0;
         en_q        <= '0;
         dp_q        <= '0;
         blink_q     <= '0;
         an          <= '1;
         seg         <= 7'h7F;
         dp_n        <= 1'b1;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         an          <= an_d;
         seg         <= seg_d;
         dp_n        <= dp_n_d;
         if (load) begin
            data_q  <= data;
            en_q    <= en;
            dp_q    <= dp;
            blink_q <= blink;
         end
      end
   end
endmodule
